// File: rtl/interleaver_ctrl.sv
// ---------------------------------------------------------------------------
// interleaver_ctrl
//
// Sequencer for a ping-pong row/column block interleaver. Two ROWS*COLS
// one-bit banks are used alternately: the bank selected by wr_bank_o is
// filled in row-major order while the other bank is read out in permuted
// (column-major) order. The block also handles zero-padding of a short final
// block and the flush of the last written block.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset
//   en_i         run enable, low forces a soft reset on the next edge
//   mode_i       0 interleave, 1 deinterleave (captured while idle)
//   in_valid_i   source offers a bit
//   in_last_i    the offered bit is the last of the stream
//   in_ready_o   bit is taken when in_valid_i & in_ready_o
//   out_ready_i  downstream can take a bit
//   wr_en_o      write strobe into bank wr_bank_o at wr_addr_o
//   wr_bank_o    bank currently being written
//   wr_addr_o    write address (row-major)
//   pad_sel_o    write data mux selects constant 0
//   rd_en_o      read strobe into bank !wr_bank_o at rd_addr_o
//   rd_addr_o    permuted read address
//   out_valid_o  read data valid, one cycle after rd_en_o
//   out_sof_o    qualifies the first bit of a block
//   out_eof_o    qualifies the last bit of the stream
//   busy_o       sequencer is not idle
// ---------------------------------------------------------------------------
module interleaver_ctrl #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              mode_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    input  logic              out_ready_i,
    output logic              wr_en_o,
    output logic              wr_bank_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              pad_sel_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              out_valid_o,
    output logic              out_sof_o,
    output logic              out_eof_o,
    output logic              busy_o
);

    localparam int N = ROWS * COLS;
    localparam logic [ADDR_W-1:0] LastCnt = ADDR_W'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StStream,
        StPad,
        StFlush
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_bank_q, wr_bank_d;
    logic              mode_q, mode_d;
    logic              prior_q, prior_d;
    logic              out_valid_q, out_sof_q, out_eof_q;

    logic step;
    logic inReady, wrEn, rdEn, padSel;
    logic cntAtLast;
    int   cntInt;

    assign cntAtLast = (cnt_q == LastCnt);

    // Handshake and bank strobes, decoded from the current state.
    // prior_q records that PAD was entered from STREAM, i.e. the other bank
    // still holds an unread block; without it PAD only writes padding and
    // runs at full rate with no read side.
    always_comb begin
        step    = 1'b0;
        inReady = 1'b0;
        wrEn    = 1'b0;
        rdEn    = 1'b0;
        padSel  = 1'b0;
        case (state_q)
            StFill: begin
                inReady = 1'b1;
                step    = in_valid_i;
                wrEn    = step;
            end
            StStream: begin
                inReady = out_ready_i;
                step    = in_valid_i & out_ready_i;
                wrEn    = step;
                rdEn    = step;
            end
            StPad: begin
                padSel = 1'b1;
                wrEn   = 1'b1;
                step   = prior_q ? out_ready_i : 1'b1;
                rdEn   = step & prior_q;
            end
            StFlush: begin
                step = out_ready_i;
                rdEn = step;
            end
            default: ;
        endcase
    end

    // Next-state logic: the shared counter advances on step and every
    // wrap at N-1 either swaps banks or ends the stream.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_bank_d = wr_bank_q;
        mode_d    = mode_q;
        prior_d   = prior_q;
        case (state_q)
            StIdle: begin
                mode_d  = mode_i;
                cnt_d   = '0;
                state_d = StFill;
            end
            StFill, StStream: begin
                if (step) begin
                    if (cntAtLast) begin
                        cnt_d     = '0;
                        wr_bank_d = ~wr_bank_q;
                        state_d   = in_last_i ? StFlush : StStream;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                        if (in_last_i) begin
                            state_d = StPad;
                            prior_d = (state_q == StStream);
                        end
                    end
                end
            end
            StPad: begin
                if (step) begin
                    if (cntAtLast) begin
                        cnt_d     = '0;
                        wr_bank_d = ~wr_bank_q;
                        state_d   = StFlush;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            StFlush: begin
                if (step) begin
                    if (cntAtLast) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Column-major read order; deinterleave swaps the roles of ROWS and COLS.
    always_comb begin
        cntInt = int'(cnt_q);
        if (mode_q) begin
            rd_addr_o = ADDR_W'((cntInt % COLS) * ROWS + cntInt / COLS);
        end else begin
            rd_addr_o = ADDR_W'((cntInt % ROWS) * COLS + cntInt / ROWS);
        end
    end

    // State register plus the output flags, delayed one cycle to line up
    // with the bank read latency. Dropping en_i abandons any partial block.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_bank_q   <= 1'b0;
            mode_q      <= 1'b0;
            prior_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_bank_q   <= wr_bank_d;
            mode_q      <= mode_d;
            prior_q     <= prior_d;
            out_valid_q <= rdEn;
            out_sof_q   <= rdEn & (cnt_q == '0);
            out_eof_q   <= rdEn & (state_q == StFlush) & cntAtLast;
        end
    end

    assign in_ready_o  = inReady;
    assign wr_en_o     = wrEn;
    assign rd_en_o     = rdEn;
    assign pad_sel_o   = padSel;
    assign wr_bank_o   = wr_bank_q;
    assign wr_addr_o   = cnt_q;
    assign out_valid_o = out_valid_q;
    assign out_sof_o   = out_sof_q;
    assign out_eof_o   = out_eof_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_interleaver_ctrl.sv
// ---------------------------------------------------------------------------
// tb_interleaver_ctrl
//
// Bench for interleaver_ctrl. dut1 is the default 4x4 instance; dut2 is a
// 2x8 instance sharing the same inputs, used for the deinterleave order.
// A small two-bank memory model follows dut1's write/read strobes so the
// scoreboard can compare read data as well as addresses and flags.
// ---------------------------------------------------------------------------
module tb_interleaver_ctrl;

    logic       clk = 1'b0;
    logic       rstN, en, mode, inValid, inLast, outReady, inData;

    logic       inReady1, wrEn1, wrBank1, padSel1, rdEn1;
    logic       outValid1, outSof1, outEof1, busy1;
    logic [3:0] wrAddr1, rdAddr1;

    logic       inReady2, wrEn2, wrBank2, padSel2, rdEn2;
    logic       outValid2, outSof2, outEof2, busy2;
    logic [3:0] wrAddr2, rdAddr2;

    typedef struct {
        int addr;
        bit data;
        bit sof;
        bit eof;
    } expT;

    expT expQ[$];
    expT pendEntry;
    bit  pendValid;
    bit  pendData;
    bit  bankMem[2][16];
    bit  streamBits[64];
    bit  monitorOn;
    bit  eofWatch, sawEof;

    int checkCount = 0;
    int errorCount = 0;
    int cycleCnt = 0;
    int outCount, firstOutCycle, lastOutCycle;

    interleaver_ctrl #(.ROWS(4), .COLS(4), .ADDR_W(4)) dut1 (
        .clk_i(clk), .rst_ni(rstN), .en_i(en), .mode_i(mode),
        .in_valid_i(inValid), .in_last_i(inLast), .in_ready_o(inReady1),
        .out_ready_i(outReady), .wr_en_o(wrEn1), .wr_bank_o(wrBank1),
        .wr_addr_o(wrAddr1), .pad_sel_o(padSel1), .rd_en_o(rdEn1),
        .rd_addr_o(rdAddr1), .out_valid_o(outValid1), .out_sof_o(outSof1),
        .out_eof_o(outEof1), .busy_o(busy1)
    );

    interleaver_ctrl #(.ROWS(2), .COLS(8), .ADDR_W(4)) dut2 (
        .clk_i(clk), .rst_ni(rstN), .en_i(en), .mode_i(mode),
        .in_valid_i(inValid), .in_last_i(inLast), .in_ready_o(inReady2),
        .out_ready_i(outReady), .wr_en_o(wrEn2), .wr_bank_o(wrBank2),
        .wr_addr_o(wrAddr2), .pad_sel_o(padSel2), .rd_en_o(rdEn2),
        .rd_addr_o(rdAddr2), .out_valid_o(outValid2), .out_sof_o(outSof2),
        .out_eof_o(outEof2), .busy_o(busy2)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used to measure gaps in the output stream.
    initial begin
        forever begin
            @(posedge clk);
            cycleCnt = cycleCnt + 1;
        end
    end

    // Scoreboard and bank model, evaluated mid-cycle. An rd_en pops the next
    // expected read and captures model data; the following cycle must show
    // out_valid with matching sof/eof/data.
    initial begin
        pendValid = 1'b0;
        monitorOn = 1'b1;
        eofWatch  = 1'b0;
        sawEof    = 1'b0;
        outCount  = 0;
        forever begin
            @(negedge clk);
            if (eofWatch && (outEof1 || outEof2)) sawEof = 1'b1;
            if (monitorOn) begin
                if (outValid1) begin
                    if (outCount == 0) firstOutCycle = cycleCnt;
                    lastOutCycle = cycleCnt;
                    outCount = outCount + 1;
                    checkCount++;
                    if (!pendValid) begin
                        errorCount++;
                        $display("[TB] FAIL out_valid: got 1 required 0 (no read issued)");
                    end else if (outSof1 !== pendEntry.sof || outEof1 !== pendEntry.eof ||
                                 pendData !== pendEntry.data) begin
                        errorCount++;
                        $display("[TB] FAIL out_bit addr %0d: sof/eof/data got %b%b%b required %b%b%b",
                                 pendEntry.addr, outSof1, outEof1, pendData,
                                 pendEntry.sof, pendEntry.eof, pendEntry.data);
                    end
                end else if (pendValid) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL out_valid: got 0 required 1");
                end
                pendValid = 1'b0;
                if (rdEn1) begin
                    checkCount++;
                    if (expQ.size() == 0) begin
                        errorCount++;
                        $display("[TB] FAIL rd_en: got 1 required 0 (no read expected)");
                    end else begin
                        pendEntry = expQ.pop_front();
                        if (rdAddr1 !== 4'(pendEntry.addr)) begin
                            errorCount++;
                            $display("[TB] FAIL rd_addr: got %0d required %0d", rdAddr1, pendEntry.addr);
                        end
                        pendData  = bankMem[!wrBank1][rdAddr1];
                        pendValid = 1'b1;
                    end
                end
                if (wrEn1) bankMem[wrBank1][wrAddr1] = padSel1 ? 1'b0 : inData;
            end
        end
    end

    // Hard stop in case a wait escapes its own bound.
    initial begin
        #500000;
        errorCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic fillRandom;
        for (int i = 0; i < 64; i++) streamBits[i] = 1'($urandom_range(0, 1));
    endtask

    // Expected read sequence for an n-bit stream on the 4x4 instance; bits
    // past n in the final block read back as padding zeros.
    task automatic pushExpected(input int n, input bit withLast);
        int nBlocks;
        nBlocks = (n + 15) / 16;
        for (int b = 0; b < nBlocks; b++) begin
            for (int k = 0; k < 16; k++) begin
                expT e;
                int  a;
                a      = (k % 4) * 4 + k / 4;
                e.addr = a;
                e.data = (b * 16 + a < n) ? streamBits[b * 16 + a] : 1'b0;
                e.sof  = (k == 0);
                e.eof  = withLast && (b == nBlocks - 1) && (k == 15);
                expQ.push_back(e);
            end
        end
    endtask

    // Offers streamBits[from..upto-1], holding each bit until in_ready.
    task automatic sendStream(input int from, input int upto, input bit lastAtEnd,
                              output bit timedOut);
        int idx;
        int guard;
        bit acc;
        idx      = from;
        guard    = 0;
        timedOut = 1'b0;
        while (idx < upto && !timedOut) begin
            inValid = 1'b1;
            inData  = streamBits[idx];
            inLast  = lastAtEnd && (idx == upto - 1);
            @(negedge clk);
            acc = inReady1;
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
            if (guard > 500) timedOut = 1'b1;
        end
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic waitIdle(output bit timedOut);
        int guard;
        guard    = 0;
        timedOut = 1'b0;
        while (busy1 && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (busy1) timedOut = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic softReset(input bit m);
        en      = 1'b0;
        inValid = 1'b0;
        inLast  = 1'b0;
        @(posedge clk);
        #1;
        en   = 1'b1;
        mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstN     = 1'b0;
        en       = 1'b0;
        mode     = 1'b0;
        inValid  = 1'b0;
        inLast   = 1'b0;
        outReady = 1'b1;
        inData   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkCount++;
        if ({inReady1, wrEn1, padSel1, rdEn1, outValid1, outSof1, outEof1, busy1, wrBank1} !== 9'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_outputs: got %b required 000000000",
                     {inReady1, wrEn1, padSel1, rdEn1, outValid1, outSof1, outEof1, busy1, wrBank1});
        end
        rstN = 1'b1;
        en   = 1'b1;
        @(negedge clk);
        checkCount++;
        if ({inReady1, wrEn1, padSel1, rdEn1, outValid1, outSof1, outEof1, busy1} !== 8'b0) begin
            errorCount++;
            $display("[TB] FAIL idle_outputs: got %b required 00000000",
                     {inReady1, wrEn1, padSel1, rdEn1, outValid1, outSof1, outEof1, busy1});
        end
        @(posedge clk);
        #1;
        checkCount++;
        if (busy1 !== 1'b1 || inReady1 !== 1'b1 || wrAddr1 !== 4'd0) begin
            errorCount++;
            $display("[TB] FAIL fill_entry: busy/in_ready/wr_addr got %b/%b/%0d required 1/1/0",
                     busy1, inReady1, wrAddr1);
        end
    endtask

    task automatic test_single_block;
        bit to;
        fillRandom();
        softReset(1'b0);
        pushExpected(16, 1'b1);
        sendStream(0, 16, 1'b1, to);
        checkCount++;
        if (to) begin
            errorCount++;
            $display("[TB] FAIL single_send: timed out got 1 required 0");
        end
        @(negedge clk);
        checkCount++;
        if ({inReady1, wrEn1, rdEn1} !== 3'b001) begin
            errorCount++;
            $display("[TB] FAIL flush_strobes: in_ready/wr_en/rd_en got %b required 001",
                     {inReady1, wrEn1, rdEn1});
        end
        @(posedge clk);
        #1;
        waitIdle(to);
        checkCount++;
        if (to || expQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL single_drain: timeout/pending got %0d/%0d required 0/0", to, expQ.size());
        end
    endtask

    task automatic test_back_to_back;
        bit to;
        bit expBank;
        fillRandom();
        softReset(1'b0);
        pushExpected(48, 1'b1);
        outCount = 0;
        for (int i = 0; i < 48; i++) begin
            inValid = 1'b1;
            inData  = streamBits[i];
            inLast  = (i == 47);
            expBank = ((i / 16) % 2) == 1;
            @(negedge clk);
            checkCount++;
            if (inReady1 !== 1'b1 || wrBank1 !== expBank || wrAddr1 !== 4'(i % 16)) begin
                errorCount++;
                $display("[TB] FAIL b2b_write bit %0d: in_ready/wr_bank/wr_addr got %b/%b/%0d required 1/%b/%0d",
                         i, inReady1, wrBank1, wrAddr1, expBank, i % 16);
            end
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        inLast  = 1'b0;
        waitIdle(to);
        checkCount++;
        if (to || expQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL b2b_drain: timeout/pending got %0d/%0d required 0/0", to, expQ.size());
        end
        checkCount++;
        if (outCount != 48 || lastOutCycle - firstOutCycle != 47) begin
            errorCount++;
            $display("[TB] FAIL b2b_gapless: count/span got %0d/%0d required 48/47",
                     outCount, lastOutCycle - firstOutCycle);
        end
    endtask

    task automatic test_backpressure;
        bit to1, to2, to3;
        fillRandom();
        softReset(1'b0);
        pushExpected(32, 1'b1);
        sendStream(0, 16, 1'b0, to1);
        sendStream(16, 19, 1'b0, to2);
        outReady = 1'b0;
        inValid  = 1'b1;
        inData   = streamBits[19];
        repeat (5) begin
            @(negedge clk);
            checkCount++;
            if ({inReady1, wrEn1, rdEn1} !== 3'b000 || wrAddr1 !== 4'd3) begin
                errorCount++;
                $display("[TB] FAIL stall: in_ready/wr_en/rd_en/cnt got %b/%0d required 000/3",
                         {inReady1, wrEn1, rdEn1}, wrAddr1);
            end
            @(posedge clk);
            #1;
        end
        outReady = 1'b1;
        sendStream(19, 32, 1'b1, to3);
        waitIdle(to1);
        checkCount++;
        if (to1 || to2 || to3 || expQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL stall_drain: timeout/pending got %0d/%0d required 0/0",
                     to1 | to2 | to3, expQ.size());
        end
    endtask

    task automatic test_pad;
        bit to;
        fillRandom();
        softReset(1'b0);
        pushExpected(21, 1'b1);
        sendStream(0, 21, 1'b1, to);
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            checkCount++;
            if ({padSel1, wrEn1, inReady1} !== 3'b110 || wrAddr1 !== 4'(5 + j)) begin
                errorCount++;
                $display("[TB] FAIL pad_write: pad_sel/wr_en/in_ready/wr_addr got %b/%0d required 110/%0d",
                         {padSel1, wrEn1, inReady1}, wrAddr1, 5 + j);
            end
            @(posedge clk);
            #1;
        end
        waitIdle(to);
        checkCount++;
        if (to || expQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL pad_drain: timeout/pending got %0d/%0d required 0/0", to, expQ.size());
        end
    endtask

    task automatic test_deinterleave_abort;
        bit to;
        int expAddr;
        monitorOn = 1'b0;
        expQ.delete();
        pendValid = 1'b0;
        fillRandom();
        softReset(1'b1);
        sendStream(0, 16, 1'b0, to);
        checkCount++;
        if (to) begin
            errorCount++;
            $display("[TB] FAIL dil_fill: timed out got 1 required 0");
        end
        mode = 1'b0;
        for (int k = 0; k < 16; k++) begin
            inValid = 1'b1;
            inData  = streamBits[16 + k];
            expAddr = (k % 8) * 2 + k / 8;
            @(negedge clk);
            checkCount++;
            if (rdEn2 !== 1'b1 || rdAddr2 !== 4'(expAddr)) begin
                errorCount++;
                $display("[TB] FAIL dil_rd_addr k=%0d: rd_en/rd_addr got %b/%0d required 1/%0d",
                         k, rdEn2, rdAddr2, expAddr);
            end
            @(posedge clk);
            #1;
        end
        sawEof   = 1'b0;
        eofWatch = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        en      = 1'b0;
        inValid = 1'b0;
        @(posedge clk);
        #1;
        checkCount++;
        if ({busy1, busy2, outValid1, outValid2, inReady2, wrBank2} !== 6'b0) begin
            errorCount++;
            $display("[TB] FAIL abort_idle: busy1/busy2/ov1/ov2/in_ready2/wr_bank2 got %b required 000000",
                     {busy1, busy2, outValid1, outValid2, inReady2, wrBank2});
        end
        en = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        eofWatch = 1'b0;
        checkCount++;
        if (sawEof !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL abort_eof: out_eof seen got 1 required 0");
        end
    endtask

    initial begin
        $display("[TB] starting interleaver_ctrl bench");
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_pad();
        test_deinterleave_abort();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
